pcm_sample_feed: RTL and testbench

Upstream stage of the I2S DAC interface. Unpacks PCM bytes from the audio FIFO (8/16-bit, mono/stereo), paces sample fetches with a phase accumulator stepped on each DAC `next_sample` request, applies a 4-bit logarithmic volume, and holds 24-bit signed left/right words stable for the DAC to latch.

---
 rtl/pcm_sample_feed_pkg.sv | 52 +++++
 rtl/pcm_volume.sv | 23 ++
 rtl/pcm_sample_feed.sv | 146 ++++++++++++++
 tb/tb_pcm_sample_feed.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_sample_feed_pkg.sv
// Shared audio constants for the PCM sample feed: FSM states, sample widths,
// logarithmic gain table and frame-size encoding.
package pcm_sample_feed_pkg;

  localparam int unsigned SampleW = 24;
  localparam int unsigned PcmW    = 16;
  localparam int unsigned GainW   = 8;
  localparam int unsigned NeedW   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StScale
  } state_e;

  // Roughly 3 dB per volume step; 128 is unity gain.
  function automatic logic [GainW-1:0] gain_lut(input logic [3:0] volume);
    logic [GainW-1:0] g;
    unique case (volume)
      4'd0:    g = 8'd0;
      4'd1:    g = 8'd1;
      4'd2:    g = 8'd1;
      4'd3:    g = 8'd2;
      4'd4:    g = 8'd3;
      4'd5:    g = 8'd4;
      4'd6:    g = 8'd6;
      4'd7:    g = 8'd8;
      4'd8:    g = 8'd11;
      4'd9:    g = 8'd16;
      4'd10:   g = 8'd23;
      4'd11:   g = 8'd32;
      4'd12:   g = 8'd45;
      4'd13:   g = 8'd64;
      4'd14:   g = 8'd91;
      default: g = 8'd128;
    endcase
    return g;
  endfunction

  // Bytes per frame: (16-bit ? 2 : 1) x (stereo ? 2 : 1).
  function automatic logic [NeedW-1:0] frame_need(input logic stereo, input logic wide);
    logic [NeedW-1:0] n;
    unique case ({wide, stereo})
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      2'b10:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pcm_volume.sv
// Combinational volume stage: log gain lookup and signed 16x8 multiply,
// producing a 24-bit word scaled so that unity gain maps full scale to full scale.
module pcm_volume
  import pcm_sample_feed_pkg::*;
(
  input  logic [3:0]         volume,
  input  logic [PcmW-1:0]    sample,
  output logic [SampleW-1:0] scaled
);

  logic signed [SampleW-1:0] s_ext;
  logic signed [SampleW-1:0] g_ext;
  logic signed [SampleW-1:0] prod;

  // |s16 x g| <= 2^22, so a 24-bit product never overflows; the final <<1 may wrap.
  always_comb begin
    s_ext  = {{(SampleW - PcmW){sample[PcmW-1]}}, sample};
    g_ext  = {{(SampleW - GainW){1'b0}}, gain_lut(volume)};
    prod   = s_ext * g_ext;
    scaled = prod << 1;
  end

endmodule

// File: rtl/pcm_sample_feed.sv
// Fetches PCM frames from the audio FIFO at a rate set by a phase accumulator,
// applies volume and holds 24-bit left/right words for the DAC.
module pcm_sample_feed
  import pcm_sample_feed_pkg::*;
#(
  parameter int unsigned FIFO_LVL_W = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  next_sample,
  input  logic [7:0]            fifo_rddata,
  input  logic [FIFO_LVL_W-1:0] fifo_level,
  output logic                  fifo_rd,
  input  logic                  mode_stereo,
  input  logic                  mode_16bit,
  input  logic [7:0]            rate,
  input  logic [3:0]            volume,
  output logic [SampleW-1:0]    left_data,
  output logic [SampleW-1:0]    right_data,
  output logic                  underrun
);

  state_e               state_q, state_d;
  logic [6:0]           acc_q, acc_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [NeedW-1:0]     need_q, need_d;
  logic                 stereo_q, stereo_d;
  logic                 wide_q, wide_d;
  logic [3:0][7:0]      slot_q, slot_d;
  logic [SampleW-1:0]   left_q, left_d;
  logic [SampleW-1:0]   right_q, right_d;
  logic                 underrun_q, underrun_d;

  logic [7:0]           step;
  logic [7:0]           sum;
  logic                 due;
  logic [NeedW-1:0]     need_now;
  logic                 level_ok;
  logic [PcmW-1:0]      left16, right16, right_raw;
  logic [SampleW-1:0]   vol_left, vol_right;

  // Rates of 128 and above saturate to one fetch per request.
  assign step     = rate[7] ? 8'd128 : rate;
  assign sum      = {1'b0, acc_q} + step;
  assign due      = next_sample & sum[7];
  assign need_now = frame_need(mode_stereo, mode_16bit);
  assign level_ok = fifo_level >= FIFO_LVL_W'(need_now);

  // Slots hold bytes in arrival order; 8-bit samples occupy the high byte.
  assign left16    = wide_q ? {slot_q[1], slot_q[0]} : {slot_q[0], 8'h00};
  assign right_raw = wide_q ? {slot_q[3], slot_q[2]} : {slot_q[1], 8'h00};
  assign right16   = stereo_q ? right_raw : left16;

  pcm_volume u_vol_left (
    .volume (volume),
    .sample (left16),
    .scaled (vol_left)
  );

  pcm_volume u_vol_right (
    .volume (volume),
    .sample (right16),
    .scaled (vol_right)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    need_d     = need_q;
    stereo_d   = stereo_q;
    wide_d     = wide_q;
    slot_d     = slot_q;
    left_d     = left_q;
    right_d    = right_q;
    underrun_d = 1'b0;
    fifo_rd    = 1'b0;

    if (next_sample) begin
      acc_d = sum[6:0];
    end

    unique case (state_q)
      StIdle: begin
        // Fetch is all-or-nothing: never pop a partial frame.
        if (due) begin
          if (level_ok) begin
            state_d  = StFetch;
            cnt_d    = 2'd0;
            need_d   = need_now;
            stereo_d = mode_stereo;
            wide_d   = mode_16bit;
          end else begin
            underrun_d = 1'b1;
          end
        end
      end
      StFetch: begin
        fifo_rd       = 1'b1;
        slot_d[cnt_q] = fifo_rddata;
        if ({1'b0, cnt_q} == need_q - 3'd1) begin
          state_d = StScale;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StScale: begin
        left_d  = vol_left;
        right_d = vol_right;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      cnt_q      <= '0;
      need_q     <= '0;
      stereo_q   <= 1'b0;
      wide_q     <= 1'b0;
      slot_q     <= '0;
      left_q     <= '0;
      right_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      need_q     <= need_d;
      stereo_q   <= stereo_d;
      wide_q     <= wide_d;
      slot_q     <= slot_d;
      left_q     <= left_d;
      right_q    <= right_d;
      underrun_q <= underrun_d;
    end
  end

  assign left_data  = left_q;
  assign right_data = right_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_pcm_sample_feed.sv
// Bench for pcm_sample_feed: constant vector table, hand-written corner sequences
// and randomized requests against an arithmetic reference model.
module tb_pcm_sample_feed;

  localparam int unsigned FIFO_LVL_W = 13;
  localparam int GAP = 512;
  localparam int MEM = 4096;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  next_sample;
  logic [7:0]            fifo_rddata;
  logic [FIFO_LVL_W-1:0] fifo_level;
  logic                  fifo_rd;
  logic                  mode_stereo;
  logic                  mode_16bit;
  logic [7:0]            rate;
  logic [3:0]            volume;
  logic [23:0]           left_data;
  logic [23:0]           right_data;
  logic                  underrun;

  pcm_sample_feed #(
    .FIFO_LVL_W (FIFO_LVL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .next_sample (next_sample),
    .fifo_rddata (fifo_rddata),
    .fifo_level  (fifo_level),
    .fifo_rd     (fifo_rd),
    .mode_stereo (mode_stereo),
    .mode_16bit  (mode_16bit),
    .rate        (rate),
    .volume      (volume),
    .left_data   (left_data),
    .right_data  (right_data),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model: the stimulus process appends, this side pops.
  logic [7:0] mem [MEM];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       rd_seen = 1'b0;

  assign fifo_rddata = mem[rd_ptr % MEM];
  assign fifo_level  = FIFO_LVL_W'(wr_ptr - rd_ptr);

  always @(negedge clk) rd_seen <= fifo_rd;
  always @(posedge clk) begin
    #1;
    if (rd_seen && rd_ptr < wr_ptr) rd_ptr <= rd_ptr + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int m_acc    = 0;
  logic [23:0] m_left  = '0;
  logic [23:0] m_right = '0;
  int last_rd  = 0;
  int gain_tab [16] = '{0, 1, 1, 2, 3, 4, 6, 8, 11, 16, 23, 32, 45, 64, 91, 128};

  typedef struct {
    logic        st;
    logic        w;
    logic [7:0]  rt;
    logic [3:0]  vol;
    int          nb;
    logic [31:0] bytes;
    int          exp_rd;
    logic        exp_ur;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % MEM] = b;
    wr_ptr++;
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  function automatic int samp8(input logic [7:0] b);
    return (b >= 8'd128) ? int'(b) - 256 : int'(b);
  endfunction

  // Reference: value = signed sample x gain x 2, kept to 24 bits.
  function automatic logic [47:0] frame_out(input logic st, input logic w,
                                            input logic [3:0] vol, input int base);
    int sl, sr, g;
    g = gain_tab[vol];
    if (w) begin
      sl = int'(mem[base % MEM]) + 256 * samp8(mem[(base + 1) % MEM]);
      sr = st ? int'(mem[(base + 2) % MEM]) + 256 * samp8(mem[(base + 3) % MEM]) : sl;
    end else begin
      sl = 256 * samp8(mem[base % MEM]);
      sr = st ? 256 * samp8(mem[(base + 1) % MEM]) : sl;
    end
    return {24'(sl * g * 2), 24'(sr * g * 2)};
  endfunction

  task automatic run_request(input string name);
    int inc, tot, need, lvl, rdc, urc;
    logic due, fetch, exp_ur;
    logic [23:0] old_l, new_l;
    logic [47:0] fr;
    inc    = (rate > 8'd128) ? 128 : int'(rate);
    tot    = m_acc + inc;
    due    = tot >= 128;
    m_acc  = tot % 128;
    need   = (mode_16bit ? 2 : 1) * (mode_stereo ? 2 : 1);
    lvl    = wr_ptr - rd_ptr;
    fetch  = due && lvl >= need;
    exp_ur = due && !fetch;
    old_l  = m_left;
    if (fetch) begin
      fr      = frame_out(mode_stereo, mode_16bit, volume, rd_ptr);
      m_left  = fr[47:24];
      m_right = fr[23:0];
    end
    new_l = m_left;
    @(negedge clk) next_sample = 1'b1;
    @(negedge clk) next_sample = 1'b0;
    rdc = 0;
    urc = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      rdc += int'(fifo_rd);
      urc += int'(underrun);
      if (k == 1) check({name, " underrun@T+1"}, underrun, exp_ur);
      if (fetch && k == need + 1) check({name, " hold@SCALE"}, left_data, old_l);
      if (fetch && k == need + 2) check({name, " left@T+need+2"}, left_data, new_l);
    end
    check({name, " rd_count"}, rdc, fetch ? need : 0);
    check({name, " underrun_count"}, urc, exp_ur ? 1 : 0);
    check({name, " left"}, left_data, m_left);
    check({name, " right"}, right_data, m_right);
    last_rd = rdc;
    repeat (GAP - 11) @(negedge clk);
  endtask

  initial begin
    logic [47:0] fr;
    int rdc, urc, tot_rd;

    vecs[0]  = '{1'b1, 1'b1, 8'd128, 4'd15, 4, 32'h7FFF8000, 4, 1'b0, 24'h800000, 24'h7FFF00};
    vecs[1]  = '{1'b0, 1'b0, 8'd128, 4'd15, 1, 32'h00000040, 1, 1'b0, 24'h400000, 24'h400000};
    vecs[2]  = '{1'b1, 1'b1, 8'd128, 4'd15, 3, 32'h00FF8000, 0, 1'b1, 24'h400000, 24'h400000};
    vecs[3]  = '{1'b0, 1'b1, 8'd255, 4'd0,  2, 32'h00004000, 2, 1'b0, 24'h000000, 24'h000000};
    vecs[4]  = '{1'b0, 1'b1, 8'd128, 4'd12, 2, 32'h00004000, 2, 1'b0, 24'h168000, 24'h168000};
    vecs[5]  = '{1'b1, 1'b0, 8'd200, 4'd15, 2, 32'h00007F80, 2, 1'b0, 24'h800000, 24'h7F0000};
    vecs[6]  = '{1'b1, 1'b0, 8'd0,   4'd15, 2, 32'h00001111, 0, 1'b0, 24'h800000, 24'h7F0000};
    vecs[7]  = '{1'b1, 1'b1, 8'd128, 4'd13, 4, 32'hEDCC1234, 4, 1'b0, 24'h091A00, 24'hF6E600};
    vecs[8]  = '{1'b0, 1'b0, 8'd128, 4'd9,  1, 32'h000000FF, 1, 1'b0, 24'hFFE000, 24'hFFE000};
    vecs[9]  = '{1'b1, 1'b1, 8'd128, 4'd15, 0, 32'h00000000, 0, 1'b1, 24'hFFE000, 24'hFFE000};
    vecs[10] = '{1'b1, 1'b0, 8'd128, 4'd14, 2, 32'h0000FE01, 2, 1'b0, 24'h00B600, 24'hFE9400};

    rst = 1'b1;
    next_sample = 1'b0;
    mode_stereo = 1'b0;
    mode_16bit = 1'b0;
    rate = 8'd0;
    volume = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset left", left_data, 24'h0);
    check("reset right", right_data, 24'h0);
    check("reset fifo_rd", fifo_rd, 1'b0);
    check("reset underrun", underrun, 1'b0);
    @(negedge clk);

    // Constant vector table.
    for (int i = 0; i < 11; i++) begin
      flush();
      mode_stereo = vecs[i].st;
      mode_16bit  = vecs[i].w;
      rate        = vecs[i].rt;
      volume      = vecs[i].vol;
      for (int b = 0; b < vecs[i].nb; b++) push(vecs[i].bytes[8*b +: 8]);
      run_request($sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl_rd", i), last_rd, vecs[i].exp_rd);
      check($sformatf("vec%0d tbl_left", i), left_data, vecs[i].exp_l);
      check($sformatf("vec%0d tbl_right", i), right_data, vecs[i].exp_r);
    end

    // Volume change alone must not touch the outputs.
    flush();
    mode_stereo = 1'b0;
    mode_16bit = 1'b1;
    rate = 8'd128;
    volume = 4'd0;
    push(8'h00);
    push(8'h40);
    run_request("vol0");
    volume = 4'd12;
    repeat (30) @(negedge clk);
    check("vol change static left", left_data, 24'h0);
    check("vol change static right", right_data, 24'h0);
    push(8'h00);
    push(8'h40);
    run_request("vol12");
    check("vol12 left", left_data, 24'h168000);

    // rate 64: every second request fetches.
    flush();
    mode_16bit = 1'b0;
    volume = 4'd15;
    rate = 8'd64;
    for (int b = 0; b < 4; b++) push(8'h40);
    run_request("r64 req1");
    check("r64 req1 no fetch", last_rd, 0);
    run_request("r64 req2");
    check("r64 req2 fetch", last_rd, 1);
    check("r64 req2 left", left_data, 24'h400000);
    run_request("r64 req3");
    run_request("r64 req4");

    // Leave acc at 64, then reset during the second FETCH cycle.
    run_request("pre-reset");
    flush();
    mode_stereo = 1'b1;
    mode_16bit = 1'b1;
    rate = 8'd128;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    @(negedge clk) next_sample = 1'b1;
    @(negedge clk) next_sample = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("reset mid-fetch fifo_rd", fifo_rd, 1'b0);
    check("reset mid-fetch left", left_data, 24'h0);
    check("reset mid-fetch right", right_data, 24'h0);
    m_acc = 0;
    m_left = '0;
    m_right = '0;
    repeat (GAP) @(negedge clk);
    flush();
    push(8'h00); push(8'h80); push(8'hFF); push(8'h7F);
    rate = 8'd64;
    run_request("post-reset acc");
    check("post-reset acc cleared", last_rd, 0);
    rate = 8'd128;
    run_request("post-reset fetch");
    check("post-reset rd", last_rd, 4);
    check("post-reset left", left_data, 24'h800000);
    check("post-reset right", right_data, 24'h7FFF00);

    // Request during FETCH is dropped without underrun.
    flush();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    push(8'h00); push(8'h80); push(8'hFF); push(8'h7F);
    fr = frame_out(1'b1, 1'b1, 4'd15, rd_ptr);
    m_left = fr[47:24];
    m_right = fr[23:0];
    rdc = 0;
    urc = 0;
    @(negedge clk) next_sample = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      next_sample = (k == 2);
      rdc += int'(fifo_rd);
      urc += int'(underrun);
    end
    check("busy drop rd", rdc, 4);
    check("busy drop underrun", urc, 0);
    check("busy drop left", left_data, 24'h221100);
    check("busy drop right", right_data, 24'h443300);
    repeat (GAP) @(negedge clk);

    // rate 0: nothing happens.
    flush();
    for (int b = 0; b < 4; b++) push(8'h5A);
    rate = 8'd0;
    tot_rd = 0;
    for (int i = 0; i < 10; i++) begin
      run_request($sformatf("rate0 #%0d", i));
      tot_rd += last_rd;
    end
    check("rate0 total rd", tot_rd, 0);

    // Randomized requests against the model.
    for (int i = 0; i < 40; i++) begin
      int nb;
      flush();
      mode_stereo = 1'($urandom_range(0, 1));
      mode_16bit  = 1'($urandom_range(0, 1));
      rate        = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      volume      = 4'($urandom_range(0, 15));
      nb          = $urandom_range(0, 4);
      for (int b = 0; b < nb; b++) push(8'($urandom_range(0, 255)));
      run_request($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
